lab_digitize_scheduler: RTL



---
 rtl/lds_pkg.sv | 23 ++
 rtl/lab_digitize_scheduler_if.sv | 11 +
 rtl/buf_id_fifo.sv | 47 ++++
 rtl/lab_digitize_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lds_pkg.sv
// rtl/lds_pkg.sv - shared constants, FSM states and helpers for the LAB digitize scheduler
package lds_pkg;

    localparam int NBUF  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_SETTLE
    } state_t;

    function automatic logic [NBUF-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NBUF-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lab_digitize_scheduler_if.sv
// rtl/lab_digitize_scheduler_if.sv - digitize/done handshake towards the LAB readout block
interface lab_digitize_scheduler_if;
    import lds_pkg::*;

    logic [NBUF-1:0] digitize_o;
    logic            done_i;

    modport master (output digitize_o, input done_i);
    modport slave  (input digitize_o, output done_i);

endinterface

// File: rtl/buf_id_fifo.sv
// rtl/buf_id_fifo.sv - 4-deep first-word-fall-through FIFO of 2-bit buffer IDs
module buf_id_fifo
    import lds_pkg::*;
(
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            push_i,
    input  logic [ID_W-1:0] push_id_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] pop_id_o,
    output logic            empty_o,
    output logic            full_o
);

    logic [ID_W-1:0] mem_q [NBUF];
    logic [ID_W:0]   wr_ptr_q;
    logic [ID_W:0]   rd_ptr_q;
    logic            wr_en;
    logic            rd_en;

    // Extra pointer bit distinguishes full from empty when the index bits match
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[ID_W] != rd_ptr_q[ID_W]) &&
                      (wr_ptr_q[ID_W-1:0] == rd_ptr_q[ID_W-1:0]);
    assign wr_en    = push_i & ~full_o;
    assign rd_en    = pop_i & ~empty_o;
    assign pop_id_o = mem_q[rd_ptr_q[ID_W-1:0]];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NBUF; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[ID_W-1:0]] <= push_id_i;
                wr_ptr_q                  <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lab_digitize_scheduler.sv
// rtl/lab_digitize_scheduler.sv - turns HOLD edges into one-at-a-time LAB digitize commands
module lab_digitize_scheduler
    import lds_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic [NBUF-1:0]        hold_i,
    input  logic [NBUF-1:0]        release_i,
    lab_digitize_scheduler_if.master lab,
    output logic [NBUF-1:0]        occupied_o,
    output logic [NBUF-1:0]        digitized_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       event_cnt_o,
    output logic                   timeout_o,
    output logic [1:0]             err_o
);

    state_t          state_q, state_d;
    logic [NBUF-1:0] hold_q, pending_q, pending_d, occupied_q, occupied_d;
    logic [NBUF-1:0] digitized_q, digitized_d, digitize_q, digitize_d;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic [1:0]      err_q, err_d;
    logic [ID_W-1:0] rr_q, rr_d, cur_id_q, cur_id_d, push_id, rr_idx, fifo_id;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            armed_q, timeout_q, timeout_d, forced_q, forced_d;
    logic [NBUF-1:0] rise, rel_ok, occ_kept, accept, push_mask, set_dig;
    logic            overrun, push_en, fifo_pop, fifo_empty, fifo_full;

    // No edge is seen on the first cycle after reset, so a HOLD already high must fall first
    assign rise     = armed_q ? (hold_i & ~hold_q) : '0;
    assign rel_ok   = release_i & digitized_q;
    assign occ_kept = occupied_q & ~rel_ok;
    assign accept   = rise & ~occ_kept;
    assign overrun  = |(rise & occ_kept);

    always_comb begin
        push_en = 1'b0;
        push_id = rr_q;
        rr_idx  = rr_q;
        for (int k = 0; k < NBUF; k++) begin
            rr_idx = rr_q + ID_W'(k);
            if (!push_en && pending_q[rr_idx]) begin
                push_en = 1'b1;
                push_id = rr_idx;
            end
        end
        push_en   = push_en & ~fifo_full;
        push_mask = push_en ? id_onehot(push_id) : '0;
        rr_d      = push_en ? push_id + 1'b1 : rr_q;
    end

    buf_id_fifo u_fifo (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .push_i    (push_en),
        .push_id_i (push_id),
        .pop_i     (fifo_pop),
        .pop_id_o  (fifo_id),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        digitize_d = digitize_q;
        cur_id_d   = cur_id_q;
        fifo_pop   = 1'b0;
        set_dig    = '0;
        timeout_d  = 1'b0;
        forced_d   = forced_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_id_d = fifo_id;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                digitize_d = id_onehot(cur_id_q);
                tcnt_d     = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                tcnt_d = tcnt_q + 16'd1;
                // done wins over a coincident terminal count
                if (lab.done_i) begin
                    set_dig    = id_onehot(cur_id_q);
                    digitize_d = '0;
                    forced_d   = 1'b0;
                    state_d    = ST_SETTLE;
                end else if (tcnt_q == TIMEOUT - 16'd1) begin
                    set_dig    = id_onehot(cur_id_q);
                    digitize_d = '0;
                    timeout_d  = 1'b1;
                    forced_d   = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (forced_q || !lab.done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            digitize_q <= '0;
            cur_id_q   <= '0;
            timeout_q  <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            digitize_q <= digitize_d;
            cur_id_q   <= cur_id_d;
            timeout_q  <= timeout_d;
            forced_q   <= forced_d;
        end
    end

    assign occupied_d  = occ_kept | accept;
    assign digitized_d = (digitized_q & ~rel_ok) | set_dig;
    assign pending_d   = (pending_q & ~push_mask) | accept;
    assign event_cnt_d = event_cnt_q + CNT_W'($countones(accept));
    assign err_d       = err_q | {timeout_d, overrun};

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hold_q      <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            occupied_q  <= '0;
            digitized_q <= '0;
            event_cnt_q <= '0;
            err_q       <= '0;
            rr_q        <= '0;
        end else begin
            hold_q      <= hold_i;
            armed_q     <= 1'b1;
            pending_q   <= pending_d;
            occupied_q  <= occupied_d;
            digitized_q <= digitized_d;
            event_cnt_q <= event_cnt_d;
            err_q       <= err_d;
            rr_q        <= rr_d;
        end
    end

    assign lab.digitize_o = digitize_q;
    assign occupied_o     = occupied_q;
    assign digitized_o    = digitized_q;
    assign busy_o         = &occupied_q;
    assign event_cnt_o    = event_cnt_q;
    assign timeout_o      = timeout_q;
    assign err_o          = err_q;

endmodule
